fwd_hazard_unit: RTL

Parametrised forwarding and load-use hazard unit for the in-order pipeline, sitting beside the ID stage. It tracks a shadow pipeline of producer records for DEPTH stages after ID, resolves each ID source operand to the youngest in-flight producer, and raises a stall when that producer's data is not ready yet. Load latency, forwarding depth and register-address width are configurable. It also handles global pipeline freeze, ID flush and a saturating stall counter. The default parameters (DEPTH=2, LOAD_STAGE=2) reproduce the classic EX/MEM forwarding with a one-cycle load-use stall.

---
 rtl/fwd_hazard_unit.sv | 76 +++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding/load-use hazard unit: picks the youngest in-flight producer per source, stalls on unready loads.
// Zero-latency combinational outputs; records shift each edge unless hold freezes them, stall inserts a bubble.
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_dst,
  input  logic [1:0]        id_kind,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              hold,
  input  logic              flush,
  output logic              stall,
  output logic [2:0]        fwd_rs_stage,
  output logic [2:0]        fwd_rt_stage,
  output logic [1:0]        fwd_rs_kind,
  output logic [1:0]        fwd_rt_kind,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] K_LOAD = 2'd1;
  localparam logic [1:0] K_NONE = 2'd3;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] dst;
    logic [1:0]        kind;
  } rec_t;

  rec_t rec [DEPTH:1];
  logic rs_rdy;
  logic rt_rdy;

  // Scan oldest to youngest so the lowest matching stage is the one left selected.
  always_comb begin
    fwd_rs_stage = '0;
    fwd_rs_kind  = '0;
    rs_rdy       = 1'b1;
    fwd_rt_stage = '0;
    fwd_rt_kind  = '0;
    rt_rdy       = 1'b1;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_use_rs && id_rs != '0 && rec[k].vld && rec[k].dst == id_rs && rec[k].kind != K_NONE) begin
        fwd_rs_stage = 3'(k);
        fwd_rs_kind  = rec[k].kind;
        rs_rdy       = (rec[k].kind != K_LOAD) || (k >= LOAD_STAGE);
      end
      if (id_use_rt && id_rt != '0 && rec[k].vld && rec[k].dst == id_rt && rec[k].kind != K_NONE) begin
        fwd_rt_stage = 3'(k);
        fwd_rt_kind  = rec[k].kind;
        rt_rdy       = (rec[k].kind != K_LOAD) || (k >= LOAD_STAGE);
      end
    end
    stall = !flush && id_valid && !(rs_rdy && rt_rdy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) rec[k] <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      for (int k = DEPTH; k > 1; k--) rec[k] <= rec[k-1];
      if (!flush && !stall) rec[1] <= '{vld: id_valid, dst: id_dst, kind: id_kind};
      else                  rec[1] <= '0;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
